// File: rtl/ppb_frame_bridge_if.sv
// ----------------------------------------------------------------------------
// ppb_frame_bridge_if
// Host byte-link bundle for the PPB frame bridge.
//   rx_data/rx_valid/rx_ready : host -> bridge byte stream
//   tx_data/tx_valid/tx_ready : bridge -> host byte stream
// Modports:
//   master : host side (drives rx_*, tx_ready)
//   slave  : bridge side (drives rx_ready, tx_data, tx_valid)
// ----------------------------------------------------------------------------
interface ppb_frame_bridge_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/ppb_frame_bridge.sv
// ----------------------------------------------------------------------------
// ppb_frame_bridge
// Host-side byte-stream bridge for the PPB device vectors.
//   - Write frame: 0xA5 followed by IN_BYTES payload bytes (byte 0 first,
//     bit j of byte k -> device_inputs[8k+j]); device_inputs updates
//     atomically one cycle after the last byte, with a wr_commit pulse.
//   - Read frame: 0x5A snapshots device_outputs and streams OUT_BYTES bytes
//     back (byte 0 first, bits above OUT_BITS sent as 0).
//   - Write frames abort after TIMEOUT_CYCLES idle cycles (0 disables),
//     setting the sticky err_timeout flag.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus (slave)    : rx_data/rx_valid/rx_ready, tx_data/tx_valid/tx_ready
//   device_outputs : live observation vector (in)
//   device_inputs  : registered control vector (out)
//   wr_commit      : one-cycle pulse when device_inputs updates
//   busy           : state != IDLE
//   err_timeout    : sticky write-frame timeout flag
// Optional build macro:
//   PPB_STEP_PULSE_EN : device_inputs[1] (clk_step) self-clears one cycle
//                       after the commit that set it.
// Note: IN_BITS must exceed 8 so at least two payload bytes exist.
// ----------------------------------------------------------------------------
module ppb_frame_bridge #(
  parameter int IN_BITS        = 60,
  parameter int OUT_BITS       = 120,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  ppb_frame_bridge_if.slave   bus,
  input  logic [OUT_BITS-1:0] device_outputs,
  output logic [IN_BITS-1:0]  device_inputs,
  output logic                wr_commit,
  output logic                busy,
  output logic                err_timeout
);

  localparam int IN_BYTES  = (IN_BITS + 7) / 8;
  localparam int OUT_BYTES = (OUT_BITS + 7) / 8;
  localparam int MAX_BYTES = (IN_BYTES > OUT_BYTES) ? IN_BYTES : OUT_BYTES;
  localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int SH_IN_W   = (IN_BYTES - 1) * 8;
  localparam int PAD_W     = OUT_BYTES * 8;
  localparam int SH_OUT_W  = (OUT_BYTES > 1) ? (OUT_BYTES - 1) * 8 : 8;
  localparam int TO_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN     = (TIMEOUT_CYCLES > 0);

  localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(IN_BYTES - 1);
  localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(OUT_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_DATA = 2'd1,
    S_RD_SEND = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [TO_W-1:0]       r_tcnt;
  // Payload bytes 0..IN_BYTES-2 shift in from the top; the final byte is
  // concatenated directly at commit so the update is atomic.
  logic [SH_IN_W-1:0]    r_shadow_in;
  // Snapshot bytes 1..OUT_BYTES-1; byte 0 goes straight into r_tx_data.
  logic [SH_OUT_W-1:0]   r_shadow_out;
  logic [IN_BITS-1:0]    r_dev_in;
  logic [7:0]            r_tx_data;
  logic                  r_tx_valid;
  logic                  r_wr_commit;
  logic                  r_busy;
  logic                  r_err;

  logic                  w_rx_ready;
  logic                  w_rx_fire;
  logic                  w_tx_fire;
  logic                  w_start_wr;
  logic                  w_start_rd;
  logic                  w_store;
  logic                  w_commit;
  logic                  w_abort;
  logic                  w_send_next;
  logic                  w_send_last;
  logic [PAD_W-1:0]      w_dout_pad;

  assign w_rx_ready = !reset && (r_state != S_RD_SEND);
  assign w_rx_fire  = bus.rx_valid && w_rx_ready;
  assign w_tx_fire  = r_tx_valid && bus.tx_ready;

  assign bus.rx_ready  = w_rx_ready;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign device_inputs = r_dev_in;
  assign wr_commit     = r_wr_commit;
  assign busy          = r_busy;
  assign err_timeout   = r_err;

  always_comb begin
    w_dout_pad = '0;
    w_dout_pad[OUT_BITS-1:0] = device_outputs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_wr  = 1'b0;
    w_start_rd  = 1'b0;
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    w_send_next = 1'b0;
    w_send_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          if (bus.rx_data == 8'hA5) begin
            w_start_wr  = 1'b1;
            w_state_nxt = S_WR_DATA;
          end else if (bus.rx_data == 8'h5A) begin
            w_start_rd  = 1'b1;
            w_state_nxt = S_RD_SEND;
          end
        end
      end
      S_WR_DATA: begin
        // An accepted byte takes priority over a timeout on the same cycle.
        if (w_rx_fire) begin
          if (r_idx == IN_LAST) begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_store = 1'b1;
          end
        end else if (TO_EN && (r_tcnt == TO_LIM)) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_SEND: begin
        if (w_tx_fire) begin
          if (r_idx == OUT_LAST) begin
            w_send_last = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_send_next = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_tcnt       <= '0;
      r_shadow_in  <= '0;
      r_shadow_out <= '0;
      r_dev_in     <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_wr_commit  <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wr_commit <= w_commit;
      r_busy      <= (w_state_nxt != S_IDLE);

`ifdef PPB_STEP_PULSE_EN
      // clk_step self-clears the cycle after its commit: one-cycle pulse.
      if (r_wr_commit) begin
        r_dev_in[1] <= 1'b0;
      end
`endif

      if (w_start_wr) begin
        r_idx       <= '0;
        r_tcnt      <= '0;
        r_err       <= 1'b0;
        r_shadow_in <= '0;
      end

      if (w_store) begin
        r_shadow_in <= {bus.rx_data, r_shadow_in[SH_IN_W-1:8]};
        r_idx       <= r_idx + IDX_W'(1);
        r_tcnt      <= '0;
      end

      if (w_commit) begin
        // Bits of the last byte above IN_BITS-1 fall off in the cast.
        r_dev_in <= IN_BITS'({bus.rx_data, r_shadow_in});
        r_idx    <= '0;
        r_tcnt   <= '0;
      end

      // Counter saturates at the limit; the abort fires from that value.
      if ((r_state == S_WR_DATA) && !w_rx_fire && TO_EN && (r_tcnt != TO_LIM)) begin
        r_tcnt <= r_tcnt + TO_W'(1);
      end

      if (w_abort) begin
        r_err       <= 1'b1;
        r_idx       <= '0;
        r_tcnt      <= '0;
        r_shadow_in <= '0;
      end

      if (w_start_rd) begin
        r_err        <= 1'b0;
        r_idx        <= '0;
        r_tx_valid   <= 1'b1;
        r_tx_data    <= w_dout_pad[7:0];
        r_shadow_out <= SH_OUT_W'(w_dout_pad >> 8);
      end

      if (w_send_next) begin
        r_tx_data    <= r_shadow_out[7:0];
        r_shadow_out <= SH_OUT_W'(r_shadow_out >> 8);
        r_idx        <= r_idx + IDX_W'(1);
      end

      if (w_send_last) begin
        r_tx_valid <= 1'b0;
        r_tx_data  <= '0;
        r_idx      <= '0;
      end
    end
  end

endmodule
